// File: rtl/alu_seq_pkg.sv
// Shared types for the handshaked sequential ALU: opcode, flag word and FSM states.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        ADC  = 4'd2,
        SBC  = 4'd3,
        AND  = 4'd4,
        OR   = 4'd5,
        XOR  = 4'd6,
        NOT  = 4'd7,
        RL   = 4'd8,
        RR   = 4'd9,
        SLA  = 4'd10,
        SRA  = 4'd11,
        SRL  = 4'd12,
        MULU = 4'd13,
        DIVU = 4'd14
    } op_t;

    typedef struct packed {
        logic s;
        logic z;
        logic v;
        logic n;
        logic c;
    } flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic             cin;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    flags_t           flags;

    modport master (
        output in_valid, op, cin, x, y, out_ready,
        input  in_ready, out_valid, result_lo, result_hi, flags
    );

    modport slave (
        input  in_valid, op, cin, x, y, out_ready,
        output in_ready, out_valid, result_lo, result_hi, flags
    );

endinterface

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiply / restoring divide datapath, one bit per cycle.
// Divide hardware exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
`ifdef ALU_SEQ_DIV_EN
    input  logic             div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic [WIDTH:0]     sum;

    // Multiply: acc = {partial, multiplier}; add on multiplier LSB, shift right.
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{acc_q[0]}}};

`ifdef ALU_SEQ_DIV_EN
    logic           div_q;
    logic [WIDTH:0] t;
    logic [WIDTH-1:0] rem_sub;

    // Divide: acc = {remainder, dividend}; shift left, subtract if it fits.
    assign t       = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_sub = t[WIDTH-1:0] - b_q;
`endif

    always_comb begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        if (div_q) begin
            if (t >= {1'b0, b_q}) begin
                acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {t[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
    assign lo_o   = acc_d[WIDTH-1:0];
    assign hi_o   = acc_d[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start_i) begin
            acc_q <= {{WIDTH{1'b0}}, a_i};
            b_q   <= b_i;
            cnt_q <= '0;
            run_q <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
            div_q <= div_i;
`endif
        end else if (run_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: FSM, single-cycle datapath and output registers.
// DIVU is implemented only when ALU_SEQ_DIV_EN is defined; otherwise it is an illegal op.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    alu_seq_if.slave   bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, hi_q;
    flags_t           flags_q;

    logic             accept, multi, start;
    logic             it_done;
    logic [WIDTH-1:0] it_lo, it_hi;

    logic [WIDTH-1:0] sc_lo;
    flags_t           sc_f, m_f;
    logic [WIDTH:0]   xe, ye, ce, sum;
    logic             is_add, is_sub, is_logic, legal;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == EXEC) || (state_q == DONE);
    assign bus.result_lo = lo_q;
    assign bus.result_hi = hi_q;
    assign bus.flags     = flags_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign start  = accept && multi;

    always_comb begin
        multi = (bus.op == MULU);
`ifdef ALU_SEQ_DIV_EN
        if (bus.op == DIVU) begin
            multi = 1'b1;
        end
`endif
    end

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
`ifdef ALU_SEQ_DIV_EN
        .div_i   (bus.op == DIVU),
`endif
        .a_i     (bus.x),
        .b_i     (bus.y),
        .done_o  (it_done),
        .lo_o    (it_lo),
        .hi_o    (it_hi)
    );

    assign xe = {1'b0, bus.x};
    assign ye = {1'b0, bus.y};
    assign ce = {{WIDTH{1'b0}}, bus.cin};

    always_comb begin
        sc_lo    = '0;
        sc_f     = '0;
        sum      = '0;
        is_add   = 1'b0;
        is_sub   = 1'b0;
        is_logic = 1'b0;
        legal    = 1'b1;
        case (bus.op)
            ADD:     begin sum = xe + ye;      is_add = 1'b1; end
            ADC:     begin sum = xe + ye + ce; is_add = 1'b1; end
            SUB:     begin sum = xe - ye;      is_sub = 1'b1; end
            SBC:     begin sum = xe - ye - ce; is_sub = 1'b1; end
            AND:     begin sc_lo = bus.x & bus.y; is_logic = 1'b1; end
            OR:      begin sc_lo = bus.x | bus.y; is_logic = 1'b1; end
            XOR:     begin sc_lo = bus.x ^ bus.y; is_logic = 1'b1; end
            NOT:     begin sc_lo = ~bus.x;        is_logic = 1'b1; end
            RL:      begin sc_lo = {bus.x[WIDTH-2:0], bus.cin};      sc_f.c = bus.x[WIDTH-1]; end
            RR:      begin sc_lo = {bus.cin, bus.x[WIDTH-1:1]};      sc_f.c = bus.x[0]; end
            SLA:     begin sc_lo = {bus.x[WIDTH-2:0], 1'b0};         sc_f.c = bus.x[WIDTH-1]; end
            SRA:     begin sc_lo = {bus.x[WIDTH-1], bus.x[WIDTH-1:1]}; sc_f.c = bus.x[0]; end
            SRL:     begin sc_lo = {1'b0, bus.x[WIDTH-1:1]};         sc_f.c = bus.x[0]; end
            default: legal = 1'b0;
        endcase
        if (is_add || is_sub) begin
            sc_lo  = sum[WIDTH-1:0];
            sc_f.c = sum[WIDTH];
            sc_f.n = is_add;
            sc_f.v = is_add ? ((bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (sum[WIDTH-1] != bus.x[WIDTH-1]))
                            : ((bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (sum[WIDTH-1] != bus.x[WIDTH-1]));
        end
        if (is_logic) begin
            sc_f.v = ~^sc_lo;
        end
        if (legal) begin
            sc_f.s = sc_lo[WIDTH-1];
            sc_f.z = (sc_lo == '0);
        end
    end

`ifdef ALU_SEQ_DIV_EN
    logic div_q, dz_q;
`endif

    always_comb begin
        m_f   = '0;
        m_f.s = it_hi[WIDTH-1];
        m_f.z = ({it_hi, it_lo} == '0);
        m_f.c = (it_hi != '0);
        m_f.v = (it_hi != '0);
`ifdef ALU_SEQ_DIV_EN
        if (div_q) begin
            m_f   = '0;
            m_f.s = it_lo[WIDTH-1];
            m_f.z = (it_lo == '0);
            m_f.v = dz_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = multi ? BUSY : EXEC;
            EXEC:    state_d = bus.out_ready ? IDLE : DONE;
            BUSY:    if (it_done) state_d = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_d = accept ? (multi ? BUSY : EXEC) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            flags_q <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept && !multi) begin
                lo_q    <= sc_lo;
                hi_q    <= '0;
                flags_q <= sc_f;
            end else if (it_done) begin
                lo_q    <= it_lo;
                hi_q    <= it_hi;
                flags_q <= m_f;
            end
`ifdef ALU_SEQ_DIV_EN
            if (accept) begin
                div_q <= (bus.op == DIVU);
                dz_q  <= (bus.y == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; DIVU expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_t        op;
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        logic [7:0] lo;
        logic [4:0] f;
    } vec_t;

    // Issue one request, measure accept->out_valid latency (1 = valid right after accept edge).
    task automatic run_op(input op_t op, input logic [7:0] a, input logic [7:0] b, input logic c,
                          input bit ack, output int lat, output logic [7:0] lo,
                          output logic [7:0] hi, output logic [4:0] f, output bit rdy_busy);
        int n;
        @(negedge clk);
        bus.op = op; bus.x = a; bus.y = b; bus.cin = c;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.x = 8'h5A; bus.y = 8'hC3; bus.cin = ~c; bus.op = ADD;
        lat = 1; rdy_busy = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_busy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = 999;
        lo = bus.result_lo; hi = bus.result_hi; f = bus.flags;
        if (ack) begin
            @(negedge clk); bus.out_ready = 1'b1;
            @(posedge clk); #1; bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.op = MULU; bus.x = 8'hFF; bus.y = 8'hFF; bus.cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.out_valid, bus.result_lo, bus.result_hi, bus.flags} !== 22'h0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b lo=%h hi=%h f=%b, expected all zero",
                     bus.out_valid, bus.result_lo, bus.result_hi, bus.flags);
        end
        @(negedge clk); bus.in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_single_ops();
        vec_t v[17];
        int lat; logic [7:0] lo, hi; logic [4:0] f; bit rb;
        v = '{
            '{ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 5'b10110},
            '{ADD, 8'h80, 8'h80, 1'b0, 8'h00, 5'b01111},
            '{ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 5'b01011},
            '{SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 5'b10001},
            '{SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 5'b00100},
            '{SBC, 8'h10, 8'h0F, 1'b1, 8'h00, 5'b01000},
            '{AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 5'b00100},
            '{OR,  8'h01, 8'h00, 1'b0, 8'h01, 5'b00000},
            '{XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 5'b01100},
            '{NOT, 8'h00, 8'h12, 1'b0, 8'hFF, 5'b10100},
            '{RL,  8'h81, 8'h00, 1'b0, 8'h02, 5'b00001},
            '{RL,  8'h00, 8'h00, 1'b1, 8'h01, 5'b00000},
            '{RR,  8'h01, 8'h00, 1'b1, 8'h80, 5'b10001},
            '{SLA, 8'h80, 8'h00, 1'b1, 8'h00, 5'b01001},
            '{SRA, 8'h81, 8'h00, 1'b0, 8'hC0, 5'b10001},
            '{SRL, 8'h01, 8'h00, 1'b1, 8'h00, 5'b01001},
            '{op_t'(4'hF), 8'hFF, 8'hFF, 1'b1, 8'h00, 5'b00000}
        };
        foreach (v[i]) begin
            run_op(v[i].op, v[i].x, v[i].y, v[i].c, 1'b1, lat, lo, hi, f, rb);
            tests++;
            if (lat !== 1) begin
                fails++;
                $display("FAIL single_latency[%0d]: got %0d cycles, expected 1", i, lat);
            end
            tests++;
            if ({lo, hi, f} !== {v[i].lo, 8'h00, v[i].f}) begin
                fails++;
                $display("FAIL single_result[%0d] op=%0d: got lo=%h hi=%h f=%b, expected lo=%h hi=00 f=%b",
                         i, v[i].op, lo, hi, f, v[i].lo, v[i].f);
            end
        end
    endtask

    task automatic test_mulu();
        vec_t v[3];
        logic [7:0] ehi[3];
        int lat; logic [7:0] lo, hi; logic [4:0] f; bit rb;
        v = '{
            '{MULU, 8'hFF, 8'hFF, 1'b0, 8'h01, 5'b10101},
            '{MULU, 8'h0D, 8'h0B, 1'b1, 8'h8F, 5'b00000},
            '{MULU, 8'h00, 8'h55, 1'b0, 8'h00, 5'b01000}
        };
        ehi = '{8'hFE, 8'h00, 8'h00};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].x, v[i].y, v[i].c, 1'b1, lat, lo, hi, f, rb);
            tests++;
            if (lat !== 9) begin
                fails++;
                $display("FAIL mulu_latency[%0d]: got %0d cycles, expected 9", i, lat);
            end
            tests++;
            if (rb !== 1'b0) begin
                fails++;
                $display("FAIL mulu_in_ready[%0d]: in_ready seen 1 while busy, expected 0", i);
            end
            tests++;
            if ({lo, hi, f} !== {v[i].lo, ehi[i], v[i].f}) begin
                fails++;
                $display("FAIL mulu_result[%0d]: got lo=%h hi=%h f=%b, expected lo=%h hi=%h f=%b",
                         i, lo, hi, f, v[i].lo, ehi[i], v[i].f);
            end
        end
    endtask

    task automatic test_divu();
        int lat; logic [7:0] lo, hi; logic [4:0] f; bit rb;
`ifdef ALU_SEQ_DIV_EN
        run_op(DIVU, 8'd200, 8'd7, 1'b0, 1'b1, lat, lo, hi, f, rb);
        tests++;
        if ({lat, lo, hi, f} !== {32'd9, 8'h1C, 8'h04, 5'b00000}) begin
            fails++;
            $display("FAIL divu_200_7: got lat=%0d lo=%h hi=%h f=%b, expected lat=9 lo=1c hi=04 f=00000",
                     lat, lo, hi, f);
        end
        run_op(DIVU, 8'h55, 8'h00, 1'b0, 1'b1, lat, lo, hi, f, rb);
        tests++;
        if ({lat, lo, hi, f[2], f[0]} !== {32'd9, 8'hFF, 8'h55, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL divu_by_zero: got lat=%0d lo=%h hi=%h v=%b c=%b, expected lat=9 lo=ff hi=55 v=1 c=0",
                     lat, lo, hi, f[2], f[0]);
        end
`else
        run_op(DIVU, 8'd200, 8'd7, 1'b0, 1'b1, lat, lo, hi, f, rb);
        tests++;
        if ({lat, lo, hi, f} !== {32'd1, 8'h00, 8'h00, 5'b00000}) begin
            fails++;
            $display("FAIL divu_disabled: got lat=%0d lo=%h hi=%h f=%b, expected lat=1 lo=00 hi=00 f=00000",
                     lat, lo, hi, f);
        end
        run_op(DIVU, 8'h55, 8'h00, 1'b1, 1'b1, lat, lo, hi, f, rb);
        tests++;
        if ({lat, lo, hi, f} !== {32'd1, 8'h00, 8'h00, 5'b00000}) begin
            fails++;
            $display("FAIL divu_disabled_y0: got lat=%0d lo=%h hi=%h f=%b, expected lat=1 all zero",
                     lat, lo, hi, f);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] lo, hi; logic [4:0] f; bit rb;
        run_op(XOR, 8'hA5, 8'h0F, 1'b0, 1'b0, lat, lo, hi, f, rb);
        tests++;
        if ({lat, lo, f} !== {32'd1, 8'hAA, 5'b10100}) begin
            fails++;
            $display("FAIL hold_xor: got lat=%0d lo=%h f=%b, expected lat=1 lo=aa f=10100", lat, lo, f);
        end
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = AND; bus.x = 8'hF0; bus.y = 8'h3C; bus.cin = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            tests++;
            if ({bus.out_valid, bus.in_ready, bus.result_lo, bus.result_hi, bus.flags} !==
                {1'b1, 1'b0, 8'hAA, 8'h00, 5'b10100}) begin
                fails++;
                $display("FAIL hold_stable[%0d]: got valid=%b rdy=%b lo=%h hi=%h f=%b, expected 1 0 aa 00 10100",
                         k, bus.out_valid, bus.in_ready, bus.result_lo, bus.result_hi, bus.flags);
            end
        end
        @(negedge clk); bus.out_ready = 1'b1; #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_in_ready: got %b, expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = OR; bus.x = 8'h00;
        tests++;
        if ({bus.out_valid, bus.result_lo, bus.result_hi, bus.flags} !== {1'b1, 8'h30, 8'h00, 5'b00100}) begin
            fails++;
            $display("FAIL b2b_and: got valid=%b lo=%h hi=%h f=%b, expected 1 30 00 00100",
                     bus.out_valid, bus.result_lo, bus.result_hi, bus.flags);
        end
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
        tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_drain: got valid=%b rdy=%b, expected 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [7:0] lo, hi; logic [4:0] f; bit rb;
        run_op(ADD, 8'h7F, 8'h01, 1'b0, 1'b1, lat, lo, hi, f, rb);
        @(negedge clk);
        bus.op = MULU; bus.x = 8'hFF; bus.y = 8'hFF; bus.in_valid = 1'b1;
        @(posedge clk); #1; bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
            fails++;
            $display("FAIL abort_busy: got valid=%b rdy=%b, expected 0 0", bus.out_valid, bus.in_ready);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({bus.out_valid, bus.result_lo, bus.result_hi, bus.flags} !== 22'h0) begin
            fails++;
            $display("FAIL abort_reset: got valid=%b lo=%h hi=%h f=%b, expected all zero",
                     bus.out_valid, bus.result_lo, bus.result_hi, bus.flags);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL abort_release: got in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
        end
        run_op(ADD, 8'h12, 8'h34, 1'b1, 1'b1, lat, lo, hi, f, rb);
        tests++;
        if ({lat, lo, hi, f} !== {32'd1, 8'h46, 8'h00, 5'b00010}) begin
            fails++;
            $display("FAIL abort_add: got lat=%0d lo=%h hi=%h f=%b, expected lat=1 lo=46 hi=00 f=00010",
                     lat, lo, hi, f);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = ADD;
        bus.cin = 1'b0; bus.x = '0; bus.y = '0;
        test_reset();
        test_single_ops();
        test_mulu();
        test_divu();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
